// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//
// Contents:
//   FWD_REGFILE  forwarding select value meaning "read the register file"
//   EX/MEM/WB    stage indices of the tracked stages after ID
//   MAX_AW       widest register address an entry can hold
//   entry_t      one tracked pipeline stage: valid, rd, we, is_load
package pipe_pkg;

    localparam int FWD_REGFILE = 0;

    localparam int EX  = 1;
    localparam int MEM = 2;
    localparam int WB  = 3;

    // Entries carry a fixed-width rd so the type can live in a package.
    // Narrower address widths are zero-extended into it.
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_src_resolve.sv
// Forwarding resolution for one ID-stage source operand.
//
// Parameters: STAGES tracked stages, AW address width, LOAD_READY first
//             stage index where load data can be forwarded.
// Ports:
//   entries   in   tracked stage entries, index 1 = EX
//   id_valid  in   ID holds a real instruction
//   src       in   source register address
//   src_used  in   the source is actually read
//   fwd       out  forwarding select, 0 = register file, k = stage k
//   unready   out  youngest producer is a load whose data is not yet ready
module src_resolve
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int AW         = 5,
    parameter int LOAD_READY = 3,
    parameter int FW         = $clog2(STAGES + 1)
) (
    input  entry_t [STAGES:1] entries,
    input  logic              id_valid,
    input  logic [AW-1:0]     src,
    input  logic              src_used,
    output logic [FW-1:0]     fwd,
    output logic              unready
);

    logic [MAX_AW-1:0] src_ext;
    logic              found;

    // The scan runs from EX outward and stops at the first match, so the
    // youngest producer of the register shadows any older one.
    always_comb begin
        src_ext         = '0;
        src_ext[AW-1:0] = src;
        fwd             = FW'(FWD_REGFILE);
        unready         = 1'b0;
        found           = 1'b0;
        if (id_valid && src_used && (src != '0)) begin
            for (int k = 1; k <= STAGES; k++) begin
                if (!found && entries[k].valid && entries[k].we &&
                    (entries[k].rd == src_ext)) begin
                    found = 1'b1;
                    if (entries[k].is_load && (k < LOAD_READY)) begin
                        unready = 1'b1;
                    end else begin
                        fwd = FW'(k);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller sitting beside the ID stage.
// Tracks in-flight destinations from EX through WB, produces forwarding
// selects, detects load-use hazards and drives the stall/flush controls.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_*                     decoded fields of the instruction in ID
//   br_taken                 taken branch/jump resolved in ID
//   mem_stall                data memory busy, freeze everything
//   flush_all                squash every in-flight instruction
//   pc_en, if_id_en          front-end load enables
//   if_id_flush, ex_bubble   NOP injection into IF_ID / ID_EXE
//   fwd_rs, fwd_rt           forwarding selects (0 = register file)
//   hazard_stall             load-use stall active this cycle
//   stall_cnt                saturating count of load-use stall cycles
//   stage_valid              per-stage valid bits, bit 0 = EX
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int AW         = 5,
    parameter int LOAD_READY = 3,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rs,
    input  logic [AW-1:0]                id_rt,
    input  logic                         id_rs_used,
    input  logic                         id_rt_used,
    input  logic [AW-1:0]                id_rd,
    input  logic                         id_we,
    input  logic                         id_is_load,
    input  logic                         br_taken,
    input  logic                         mem_stall,
    input  logic                         flush_all,
    output logic                         pc_en,
    output logic                         if_id_en,
    output logic                         if_id_flush,
    output logic                         ex_bubble,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rs,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rt,
    output logic                         hazard_stall,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [STAGES-1:0]            stage_valid
);

    entry_t [STAGES:1] entries;
    entry_t [STAGES:1] entries_next;
    logic              rs_unready;
    logic              rt_unready;
    logic [MAX_AW-1:0] id_rd_ext;

    src_resolve #(.STAGES(STAGES), .AW(AW), .LOAD_READY(LOAD_READY)) u_rs (
        .entries  (entries),
        .id_valid (id_valid),
        .src      (id_rs),
        .src_used (id_rs_used),
        .fwd      (fwd_rs),
        .unready  (rs_unready)
    );

    src_resolve #(.STAGES(STAGES), .AW(AW), .LOAD_READY(LOAD_READY)) u_rt (
        .entries  (entries),
        .id_valid (id_valid),
        .src      (id_rt),
        .src_used (id_rt_used),
        .fwd      (fwd_rt),
        .unready  (rt_unready)
    );

    // A frozen or squashed pipeline never counts as a load-use stall; once
    // mem_stall drops the hazard is re-evaluated on the frozen entries.
    assign hazard_stall = (rs_unready || rt_unready) && !mem_stall && !flush_all;

    // Pipeline control priority: flush, memory freeze, load-use, normal.
    // A branch seen during a load-use stall is not acted on; it is taken
    // again from ID once the stall clears.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        ex_bubble   = 1'b0;
        if (flush_all) begin
            if_id_flush = 1'b1;
            ex_bubble   = 1'b1;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else if (hazard_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_bubble = 1'b1;
        end else begin
            if_id_flush = br_taken;
        end
    end

    // Next state of the shift chain; the WB entry simply falls off the end.
    always_comb begin
        id_rd_ext         = '0;
        id_rd_ext[AW-1:0] = id_rd;
        entries_next      = entries;
        if (flush_all) begin
            for (int k = 1; k <= STAGES; k++) begin
                entries_next[k].valid = 1'b0;
            end
        end else if (!mem_stall) begin
            for (int k = STAGES; k >= 2; k--) begin
                entries_next[k] = entries[k-1];
            end
            if (hazard_stall) begin
                entries_next[EX] = '0;
            end else begin
                entries_next[EX].valid   = id_valid;
                entries_next[EX].rd      = id_rd_ext;
                entries_next[EX].we      = id_we;
                entries_next[EX].is_load = id_is_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
        end else begin
            entries <= entries_next;
        end
    end

    // Stall counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 1; k <= STAGES; k++) begin
            stage_valid[k-1] = entries[k].valid;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       br_taken, mem_stall, flush_all;

    logic        pc_en, if_id_en, if_id_flush, ex_bubble, hazard_stall;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [15:0] stall_cnt;
    logic [2:0]  stage_valid;

    logic        pc_en_b, if_id_en_b, if_id_flush_b, ex_bubble_b, hazard_stall_b;
    logic [2:0]  fwd_rs_b, fwd_rt_b;
    logic [15:0] stall_cnt_b;
    logic [4:0]  stage_valid_b;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .br_taken(br_taken), .mem_stall(mem_stall),
        .flush_all(flush_all), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .ex_bubble(ex_bubble), .fwd_rs(fwd_rs),
        .fwd_rt(fwd_rt), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt),
        .stage_valid(stage_valid)
    );

    pipe_hazard_ctrl #(.STAGES(5), .LOAD_READY(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .br_taken(br_taken), .mem_stall(mem_stall),
        .flush_all(flush_all), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
        .if_id_flush(if_id_flush_b), .ex_bubble(ex_bubble_b), .fwd_rs(fwd_rs_b),
        .fwd_rt(fwd_rt_b), .hazard_stall(hazard_stall_b), .stall_cnt(stall_cnt_b),
        .stage_valid(stage_valid_b)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the ID stage; inputs settle 1 time unit before being checked.
    task automatic apply_stimulus(input logic v, input logic [4:0] rs, input logic rs_u,
                                  input logic [4:0] rt, input logic rt_u,
                                  input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v;  id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
        id_rd = rd;    id_we = we; id_is_load = ld;
        #1;
    endtask

    task automatic set_idle();
        br_taken = 1'b0; mem_stall = 1'b0; flush_all = 1'b0;
        apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_idle();
        repeat (5) tick();
    endtask

    initial begin
        set_idle();
        #3;
        $display("[TB] reset state");
        check_output("rst_stage_valid", 32'(stage_valid), 32'h0);
        check_output("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check_output("rst_pc_en", 32'(pc_en), 32'h1);
        check_output("rst_if_id_en", 32'(if_id_en), 32'h1);
        check_output("rst_ex_bubble", 32'(ex_bubble), 32'h0);
        check_output("rst_hazard", 32'(hazard_stall), 32'h0);
        #10 rst = 1'b1;
        tick();

        $display("[TB] ALU back-to-back dependency");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        check_output("alu_first_fwd", 32'(fwd_rs), 32'h0);
        tick();
        apply_stimulus(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        check_output("alu_fwd_rs", 32'(fwd_rs), 32'h1);
        check_output("alu_fwd_rt", 32'(fwd_rt), 32'h0);
        check_output("alu_no_stall", 32'(hazard_stall), 32'h0);
        tick();
        set_idle();
        check_output("alu_stage_valid", 32'(stage_valid), 32'h3);
        check_output("alu_stall_cnt", 32'(stall_cnt), 32'h0);
        drain();

        $display("[TB] load-use");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        check_output("lu_c1_hazard", 32'(hazard_stall), 32'h1);
        check_output("lu_c1_bubble", 32'(ex_bubble), 32'h1);
        check_output("lu_c1_pc_en", 32'(pc_en), 32'h0);
        check_output("lu_c1_if_id_en", 32'(if_id_en), 32'h0);
        tick();
        check_output("lu_c2_hazard", 32'(hazard_stall), 32'h1);
        check_output("lu_c2_bubble", 32'(ex_bubble), 32'h1);
        check_output("lu_c2_cnt", 32'(stall_cnt), 32'h1);
        tick();
        check_output("lu_c3_hazard", 32'(hazard_stall), 32'h0);
        check_output("lu_c3_fwd_rs", 32'(fwd_rs), 32'h3);
        check_output("lu_c3_pc_en", 32'(pc_en), 32'h1);
        check_output("lu_c3_cnt", 32'(stall_cnt), 32'h2);
        tick();
        drain();

        $display("[TB] producer to r0");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        check_output("r0_fwd_rs", 32'(fwd_rs), 32'h0);
        check_output("r0_fwd_rt", 32'(fwd_rt), 32'h0);
        check_output("r0_hazard", 32'(hazard_stall), 32'h0);
        tick();
        drain();

        $display("[TB] mem_stall during load-use");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        mem_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("ms_hazard_masked", 32'(hazard_stall), 32'h0);
            check_output("ms_pc_en", 32'(pc_en), 32'h0);
            check_output("ms_bubble", 32'(ex_bubble), 32'h0);
            tick();
            check_output("ms_frozen", 32'(stage_valid), 32'h1);
        end
        mem_stall = 1'b0;
        #1;
        check_output("ms_rel_hazard", 32'(hazard_stall), 32'h1);
        check_output("ms_rel_cnt", 32'(stall_cnt), 32'h2);
        tick();
        check_output("ms_rel2_hazard", 32'(hazard_stall), 32'h1);
        tick();
        check_output("ms_done_hazard", 32'(hazard_stall), 32'h0);
        check_output("ms_done_fwd_rt", 32'(fwd_rt), 32'h3);
        check_output("ms_done_cnt", 32'(stall_cnt), 32'h4);
        tick();
        drain();

        $display("[TB] branch during load-use");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        br_taken = 1'b1;
        apply_stimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_output("br_stall1_flush", 32'(if_id_flush), 32'h0);
        tick();
        check_output("br_stall2_flush", 32'(if_id_flush), 32'h0);
        tick();
        check_output("br_clear_flush", 32'(if_id_flush), 32'h1);
        check_output("br_clear_cnt", 32'(stall_cnt), 32'h6);
        tick();
        set_idle();
        check_output("br_pulse_end", 32'(if_id_flush), 32'h0);
        drain();

        $display("[TB] flush_all");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + i), 1'b1, 1'b0);
            tick();
        end
        check_output("fl_three_valid", 32'(stage_valid), 32'h7);
        flush_all = 1'b1;
        mem_stall = 1'b1;
        #1;
        check_output("fl_if_id_flush", 32'(if_id_flush), 32'h1);
        check_output("fl_bubble", 32'(ex_bubble), 32'h1);
        check_output("fl_pc_en_wins", 32'(pc_en), 32'h1);
        tick();
        check_output("fl_stage_valid", 32'(stage_valid), 32'h0);
        check_output("fl_cnt_kept", 32'(stall_cnt), 32'h6);
        drain();

        $display("[TB] async reset mid-stall");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("ar_pre_valid", 32'(stage_valid), 32'h2);
        check_output("ar_pre_cnt", 32'(stall_cnt), 32'h7);
        #2 rst = 1'b0;
        #1;
        check_output("ar_stage_valid", 32'(stage_valid), 32'h0);
        check_output("ar_cnt", 32'(stall_cnt), 32'h0);
        check_output("ar_hazard", 32'(hazard_stall), 32'h0);
        check_output("ar_pc_en", 32'(pc_en), 32'h1);
        check_output("ar_b_cnt", 32'(stall_cnt_b), 32'h0);
        set_idle();
        tick();
        #2 rst = 1'b1;
        tick();

        $display("[TB] STAGES=5 LOAD_READY=4 load-use");
        apply_stimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        check_output("b_after_load", 32'(stage_valid_b), 32'h01);
        apply_stimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_output("b_hazard", 32'(hazard_stall_b), 32'h1);
            check_output("b_bubble", 32'(ex_bubble_b), 32'h1);
            tick();
        end
        check_output("b_done_hazard", 32'(hazard_stall_b), 32'h0);
        check_output("b_done_fwd_rs", 32'(fwd_rs_b), 32'h4);
        check_output("b_done_cnt", 32'(stall_cnt_b), 32'h3);
        check_output("b_done_valid", 32'(stage_valid_b), 32'h08);
        tick();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised in-order pipeline controller for the MIPS pipeline core. It tracks the destination register of every in-flight instruction from EX through WB, generates per-operand forwarding selects for the ID stage, and detects load-use hazards at any configurable load latency. It produces the PC / IF_ID enable, IF_ID flush and EX bubble controls that the fixed-depth pipeline currently lacks. It sits beside the ID stage, with the decoder and control unit feeding it and the pipeline registers consuming its outputs.

## Interface
- STAGES, 3: number of tracked stages after ID. Index 1 = EX, index STAGES = WB.
- AW, 5: register-address width.
- LOAD_READY, 3: lowest stage index at which load data is forwardable. Range 1..STAGES.
- CNT_W, 16: stall-counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register addresses.
- id_rs_used, id_rt_used  in  1  the source is actually read.
- id_rd  in  AW  destination register address.
- id_we  in  1  the instruction writes a register.
- id_is_load  in  1  the instruction is a load.
- br_taken  in  1  taken branch or jump resolved in ID.
- mem_stall  in  1  data memory busy; freeze the whole pipeline.
- flush_all  in  1  squash every in-flight instruction.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF_ID load enable.
- if_id_flush  out  1  load NOP into IF_ID.
- ex_bubble  out  1  load NOP into ID_EXE.
- fwd_rs, fwd_rt  out  $clog2(STAGES+1)  forwarding source. 0 = register file; k = tracked stage k.
- hazard_stall  out  1  load-use stall is active this cycle.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.
- stage_valid  out  STAGES  per-stage valid bits, for debug.

## Operation
- Each tracked stage entry holds valid, rd, we, is_load.
- Entry k is a forwarding candidate for source s when all hold: valid[k], we[k], rd[k]==s, s!=0, s_used, id_valid.
- Source resolution: take the candidate with the smallest index k (youngest producer wins).
  - If it is a load and k < LOAD_READY, the source is unready.
  - Otherwise fwd = k.
  - If there is no candidate, fwd = 0.
- hazard_stall = (rs unready or rt unready) and not mem_stall and not flush_all.
- Priority, highest first:
  1. flush_all: all entries become invalid; if_id_flush=1; ex_bubble=1; pc_en=1; counter unchanged.
  2. mem_stall: every entry holds; pc_en=0; if_id_en=0; ex_bubble=0; if_id_flush=0.
  3. hazard_stall: entries 2..STAGES shift from 1..STAGES-1; entry 1 becomes invalid; ex_bubble=1; pc_en=0; if_id_en=0; br_taken is ignored (if_id_flush=0); stall_cnt increments, saturating at all-ones.
  4. Normal: entries shift; entry 1 loads the ID fields with valid = id_valid; pc_en=1; if_id_en=1; if_id_flush = br_taken.
- The WB entry drops off the end of the shift chain.
- All outputs except stall_cnt and stage_valid are combinational from state and inputs.

## Timing
- Reset values: all valid=0, stall_cnt=0. With inputs idle, this gives pc_en=1, if_id_en=1, fwd=0, ex_bubble=0, hazard_stall=0.
- Reset asserted mid-stall clears the state immediately, without waiting for a clock edge.
- Forwarding selects are valid in the same cycle as the ID inputs.
- Load-use with defaults: a load in EX stalls its dependent for exactly 1 cycle. The load then sits in MEM (index 2 < 3), so the dependent stalls a 2nd cycle. It resumes when the load reaches WB (fwd=3). Total stall = LOAD_READY-1 cycles.
- While mem_stall is high, hazard_stall is masked. On release, hazard detection re-evaluates on the frozen state.
- br_taken together with hazard_stall: the branch re-evaluates on the cycle after the stall clears and flushes then.
- flush_all together with mem_stall: flush_all wins.

## Structure
- Shared package pipe_pkg:
  - FWD_REGFILE = 0.
  - Stage-index constants EX = 1, MEM = 2, WB = 3.
  - Entry typedef {valid, rd, we, is_load}.
- Sub-module src_resolve, instantiated twice (rs, rt). It takes the entry array and one source and returns fwd and unready. It is purely combinational and parametrised on STAGES, AW and LOAD_READY.
- Top level holds the entry shift chain, priority logic and counter.

## Test plan
- Back-to-back ALU dependency: add r3 then sub r4,r3. Expected: fwd_rs=1; no stall; stall_cnt=0.
- Load-use with defaults: lw r5 then add r6,r5. Expected: hazard_stall high 2 cycles, then fwd_rs=3; stall_cnt=2; ex_bubble high in both cycles.
- Producer to r0: writes to r0 never forward and never stall; fwd=0.
- mem_stall for 3 cycles during load-use: entries frozen; hazard_stall=0 throughout; the stall resumes after release; stall_cnt counts only hazard cycles.
- br_taken during load-use: no if_id_flush while stalled. After the stall clears, if_id_flush pulses 1 cycle.
- flush_all with 3 valid entries: stage_valid=0 next cycle. Also assert rst mid-run: all outputs return to reset values asynchronously. Repeat with STAGES=5, LOAD_READY=4 and check a 3-cycle load-use stall.
